alu_dispatch: RTL and testbench

ALU_DISPATCH -- requirements
Module: alu_dispatch

---
 rtl/alu_dispatch_pkg.sv | 29 ++
 rtl/alu_cmd_fifo.sv | 45 ++++
 rtl/alu_dispatch.sv | 123 ++++++++++++
 tb/tb_alu_dispatch.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_dispatch_pkg.sv
// Shared ALU definitions: op codes, key width and the dispatch command bundle.
// Used by alu32 and alu_dispatch.
package alu_dispatch_pkg;

  localparam int KEY_W = 8;
  localparam logic [KEY_W-1:0] KEY_NULL = '0;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_MUL = 8'h03;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // KEY_NULL is what alu32 reports when idle, so it is skipped on wrap.
  function automatic logic [KEY_W-1:0] nextKey(input logic [KEY_W-1:0] k);
    return (k == '1) ? KEY_W'(1) : k + KEY_W'(1);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue for alu_dispatch: 72-bit entries, first-word-fall-through.
// Sync reset and flush share the pointer clear.
module alu_cmd_fifo
  import alu_dispatch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t mem [DEPTH];
  logic [AW:0] wPtr;
  logic [AW:0] rPtr;

  assign empty = (wPtr == rPtr);
  assign full  = (wPtr[AW] != rPtr[AW]) &&
                 (wPtr[AW-1:0] == rPtr[AW-1:0]);
  assign dout  = mem[rPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wPtr <= '0;
      rPtr <= '0;
    end else begin
      if (push && !full) begin
        mem[wPtr[AW-1:0]] <= din;
        wPtr <= wPtr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rPtr <= rPtr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/alu_dispatch.sv
// Queues ALU commands and issues them one at a time to alu32, matching
// results by key and aborting commands that never come back.
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_err,
  output logic             alu_en,
  output logic             alu_clr,
  output logic [KEY_W-1:0] alu_key,
  output logic [7:0]       alu_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [KEY_W-1:0] alu_key_out,
  input  logic [31:0]      alu_out,
  output logic             busy
);

  state_t     state;
  logic [7:0] tmo;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  cmd_t       head;
  cmd_t       din;

  assign din       = '{op: cmd_op, a: cmd_a, b: cmd_b};
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty && !clr;
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE) || !empty;

  alu_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .push (push),
    .pop  (pop),
    .din  (din),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tmo      <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
      alu_en   <= 1'b0;
      alu_clr  <= 1'b0;
      alu_key  <= KEY_NULL;
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
    end else if (clr) begin
      state    <= IDLE;
      tmo      <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
      alu_en   <= 1'b0;
      alu_clr  <= 1'b1;
    end else begin
      alu_clr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            alu_op  <= head.op;
            alu_a   <= head.a;
            alu_b   <= head.b;
            alu_key <= nextKey(alu_key);
            alu_en  <= 1'b1;
            tmo     <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // A match wins even on the cycle the timeout would fire.
          if (alu_key_out == alu_key) begin
            res_data <= alu_out;
            res_err  <= 1'b0;
            alu_en   <= 1'b0;
            state    <= DONE;
          end else if (tmo >= 8'(TIMEOUT - 1)) begin
            res_data <= '0;
            res_err  <= 1'b1;
            alu_en   <= 1'b0;
            alu_clr  <= 1'b1;
            tmo      <= tmo + 8'd1;
            state    <= DONE;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch with a behavioural alu32 model attached.
module tb_alu_dispatch;
  import alu_dispatch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_op = '0;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic        res_err;
  logic        alu_en;
  logic        alu_clr;
  logic [7:0]  alu_key;
  logic [7:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        busy;

  logic [7:0]  aluKeyOut;
  logic [31:0] aluOut;
  logic [7:0]  mulKey;
  logic [31:0] mulRes;
  logic [2:0]  mulCnt;
  logic        stubKey = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [32:0] expQ [$];
  logic [7:0]  keyModel = '0;
  logic [7:0]  prevKey;
  bit          enPrev = 0;
  bit          wrapSeen = 0;
  int          clrCnt = 0;
  int          enCnt = 0;

  always #5 clk = ~clk;

  alu_dispatch #(
    .DEPTH  (4),
    .TIMEOUT(15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_err    (res_err),
    .alu_en     (alu_en),
    .alu_clr    (alu_clr),
    .alu_key    (alu_key),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_key_out(stubKey ? KEY_NULL : aluKeyOut),
    .alu_out    (aluOut),
    .busy       (busy)
  );

  // alu32 model: ADD/SUB/unknown answer one edge after sampling,
  // MUL keeps key_out at KEY_NULL for three more edges.
  always @(posedge clk) begin
    if (rst || alu_clr) begin
      mulCnt    <= '0;
      aluKeyOut <= KEY_NULL;
      aluOut    <= '0;
    end else if (mulCnt != 0) begin
      mulCnt <= mulCnt - 3'd1;
      if (mulCnt == 3'd1) begin
        aluKeyOut <= mulKey;
        aluOut    <= mulRes;
      end
    end else if (alu_en) begin
      case (alu_op)
        OP_ADD: begin
          aluOut    <= alu_a + alu_b;
          aluKeyOut <= alu_key;
        end
        OP_SUB: begin
          aluOut    <= alu_a - alu_b;
          aluKeyOut <= alu_key;
        end
        OP_MUL: begin
          mulRes    <= alu_a * alu_b;
          mulKey    <= alu_key;
          mulCnt    <= 3'd3;
          aluKeyOut <= KEY_NULL;
        end
        default: begin
          aluOut    <= '0;
          aluKeyOut <= alu_key;
        end
      endcase
    end else begin
      aluKeyOut <= KEY_NULL;
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: key sequence, pulse counters and result scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      keyModel = '0;
      enPrev   = 0;
    end else begin
      if (alu_en && !enPrev) begin
        prevKey  = keyModel;
        keyModel = (keyModel == 8'hFF) ? 8'h01 : keyModel + 8'h01;
        if (prevKey == 8'hFF) wrapSeen = 1;
        check("issue_key", {56'd0, alu_key}, {56'd0, keyModel});
      end
      enPrev = alu_en;
      if (alu_clr) clrCnt++;
      if (alu_en) enCnt++;
      if (res_valid && res_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0h/%0b expected none",
                   res_data, res_err);
        end else begin
          logic [32:0] e;
          e = expQ.pop_front();
          check("result", {31'd0, res_data, res_err}, {31'd0, e});
        end
      end
    end
  end

  task automatic sendCmd(input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ed,
                         input logic ee, input bit track);
    bit done = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        if (track) expQ.push_back({ed, ee});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: got no handshake required cmd_ready");
    end
  endtask

  task automatic checkLatency(input string name, input int exp);
    int n = 0;
    while (n < 100 && !res_valid) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 64'(n), 64'(exp));
  endtask

  task automatic waitIdle();
    int n = 0;
    while (n < 2000 && (busy || res_valid || expQ.size() != 0)) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy after %0d cycles required idle", n);
    end
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_flags"},
          {58'd0, cmd_ready, res_valid, res_err, alu_en, alu_clr, busy},
          64'b100000);
    check({tag, "_res_data"}, {32'd0, res_data}, 64'd0);
    check({tag, "_key_op"}, {48'd0, alu_key, alu_op}, 64'd0);
    check({tag, "_ab"}, {alu_a, alu_b}, 64'd0);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 3};
    vecs[1] = '{OP_MUL, 32'hFFFFFFFD, 32'd4, 32'hFFFFFFF4, 1'b0, 6};
    vecs[2] = '{OP_SUB, 32'd10, 32'd3, 32'd7, 1'b0, 3};
    vecs[3] = '{OP_ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 3};
    vecs[4] = '{OP_SUB, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 3};
    vecs[5] = '{8'h7F, 32'd9, 32'd9, 32'd0, 1'b0, 3};
    vecs[6] = '{OP_MUL, 32'h00010000, 32'h00010001, 32'h00010000, 1'b0, 6};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetState("reset");

    foreach (vecs[i]) begin
      sendCmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
              vecs[i].err, 1);
      checkLatency($sformatf("latency_v%0d", i), vecs[i].lat);
      waitIdle();
    end

    // Timeout: alu never answers with the issued key.
    stubKey = 1'b1;
    clrCnt  = 0;
    enCnt   = 0;
    sendCmd(OP_ADD, 32'd1, 32'd2, 32'd0, 1'b1, 1);
    waitIdle();
    check("timeout_wait_cycles", 64'(enCnt), 64'd15);
    check("timeout_clr_pulses", 64'(clrCnt), 64'd1);
    stubKey = 1'b0;

    // clr while a MUL is in WAIT with two commands queued.
    sendCmd(OP_MUL, 32'd6, 32'd7, 32'd0, 1'b0, 0);
    sendCmd(OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 0);
    sendCmd(OP_ADD, 32'd2, 32'd2, 32'd0, 1'b0, 0);
    check("clr_pre_wait", {62'd0, alu_en, busy}, 64'b11);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_after", {60'd0, busy, res_valid, alu_en, alu_clr},
          64'b0001);
    @(posedge clk);
    #1;
    check("clr_pulse_end", {63'd0, alu_clr}, 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("clr_quiet", {62'd0, busy, res_valid}, 64'd0);
    sendCmd(OP_MUL, 32'd6, 32'd7, 32'd42, 1'b0, 1);
    checkLatency("clr_next_latency", 6);
    waitIdle();

    // Backpressure: four queued plus one in flight fills the block.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sendCmd(OP_SUB, 32'(100 * (i + 1)), 32'(i), 32'(100 * (i + 1) - i),
              1'b0, 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("bp_full", {61'd0, cmd_ready, res_valid, busy}, 64'b011);
    res_ready = 1'b1;
    sendCmd(OP_SUB, 32'd600, 32'd5, 32'd595, 1'b0, 1);
    waitIdle();

    // Key wrap: 256 more issues cross 255 -> 1.
    wrapSeen = 0;
    for (int i = 0; i < 256; i++) begin
      sendCmd(OP_ADD, 32'(i), 32'(3 * i), 32'(4 * i), 1'b0, 1);
    end
    waitIdle();
    check("key_wrapped", {63'd0, wrapSeen}, 64'd1);

    // Reset mid-operation abandons the command; next key is 1.
    stubKey = 1'b1;
    sendCmd(OP_ADD, 32'd9, 32'd9, 32'd0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    stubKey = 1'b0;
    checkResetState("midrst");
    repeat (20) @(posedge clk);
    #1;
    check("midrst_quiet", {62'd0, busy, res_valid}, 64'd0);
    sendCmd(OP_ADD, 32'd20, 32'd22, 32'd42, 1'b0, 1);
    checkLatency("midrst_latency", 3);
    waitIdle();
    check("first_key_after_rst", {56'd0, alu_key}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
